// File: rtl/writeback_queue_pkg.sv
// Shared widths and constants for the writeback queue.
// REG_WIDTH mirrors the global register width; queue depth and entry field widths live alongside it.
package writeback_queue_pkg;
  localparam int REG_WIDTH     = 16;
  localparam int WBQ_DEPTH     = 4;
  localparam int WBQ_IDX_WIDTH = 4;
  localparam int WBQ_PTR_WIDTH = 2;
  localparam int WBQ_CNT_WIDTH = 3;

  // Slots left for new results once this cycle's pop (if any) has left the buffer.
  function automatic logic [WBQ_CNT_WIDTH-1:0] wbq_free_slots(
    input logic [WBQ_CNT_WIDTH-1:0] count,
    input logic                     pop
  );
    return WBQ_CNT_WIDTH'(WBQ_DEPTH) - count + {{(WBQ_CNT_WIDTH-1){1'b0}}, pop};
  endfunction
endpackage

// File: rtl/writeback_queue_entry_fifo.sv
// Circular buffer of {RegIdx, Data} entries: one pop and zero to two pushes per cycle.
module wb_entry_fifo
  import writeback_queue_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pop,
  input  logic [1:0]               push_n,
  input  logic [WBQ_IDX_WIDTH-1:0] push0_idx,
  input  logic [REG_WIDTH-1:0]     push0_data,
  input  logic [WBQ_IDX_WIDTH-1:0] push1_idx,
  input  logic [REG_WIDTH-1:0]     push1_data,
  output logic [WBQ_IDX_WIDTH-1:0] head_idx,
  output logic [REG_WIDTH-1:0]     head_data,
  output logic [WBQ_CNT_WIDTH-1:0] count
);
  logic [WBQ_IDX_WIDTH-1:0] idx_mem  [WBQ_DEPTH];
  logic [REG_WIDTH-1:0]     data_mem [WBQ_DEPTH];
  logic [WBQ_PTR_WIDTH-1:0] rd_ptr;
  logic [WBQ_PTR_WIDTH-1:0] wr_ptr;

  assign head_idx  = idx_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      wr_ptr <= wr_ptr + push_n;
      count  <= count - {2'b00, pop} + {1'b0, push_n};
    end
  end

  // Payload needs no reset: validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      idx_mem[wr_ptr]  <= push0_idx;
      data_mem[wr_ptr] <= push0_data;
    end
    if (push_n == 2'd2) begin
      idx_mem[wr_ptr + 2'd1]  <= push1_idx;
      data_mem[wr_ptr + 2'd1] <= push1_data;
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// Merges load and ALU results into a single in-order register writeback stream.
// Stored entries drain first, then Mem, then ALU; results beyond capacity are dropped youngest-first.
module writeback_queue
  import writeback_queue_pkg::*;
(
  input  logic                     I_CLOCK,
  input  logic                     I_RESET_N,
  input  logic                     I_LOCK,
  input  logic                     I_MemValid,
  input  logic [WBQ_IDX_WIDTH-1:0] I_MemRegIdx,
  input  logic [REG_WIDTH-1:0]     I_MemData,
  input  logic                     I_AluValid,
  input  logic [WBQ_IDX_WIDTH-1:0] I_AluRegIdx,
  input  logic [REG_WIDTH-1:0]     I_AluData,
  output logic                     O_WriteBackEnable,
  output logic [WBQ_IDX_WIDTH-1:0] O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]     O_WriteBackData,
  output logic                     O_QueueStall,
  output logic [2:0]               O_Count,
  output logic                     O_Overflow
);
  logic                     pop;
  logic [1:0]               push_n;
  logic [WBQ_IDX_WIDTH-1:0] p0_idx, p1_idx, cand_idx, head_idx;
  logic [REG_WIDTH-1:0]     p0_data, p1_data, cand_data, head_data;
  logic                     cand_valid;
  logic                     drop;
  logic [WBQ_CNT_WIDTH-1:0] want;
  logic [WBQ_CNT_WIDTH-1:0] free;
  logic [WBQ_CNT_WIDTH-1:0] fifo_count;

  always_comb begin
    pop        = 1'b0;
    cand_valid = 1'b0;
    cand_idx   = '0;
    cand_data  = '0;
    p0_idx     = I_MemRegIdx;
    p0_data    = I_MemData;
    p1_idx     = I_AluRegIdx;
    p1_data    = I_AluData;
    want       = '0;
    if (I_LOCK) begin
      if (fifo_count != '0) begin
        pop        = 1'b1;
        cand_valid = 1'b1;
        cand_idx   = head_idx;
        cand_data  = head_data;
        if (I_MemValid) begin
          want = 3'd1 + {2'b00, I_AluValid};
        end else if (I_AluValid) begin
          p0_idx  = I_AluRegIdx;
          p0_data = I_AluData;
          want    = 3'd1;
        end
      end else if (I_MemValid) begin
        // Empty queue: Mem bypasses to the output, ALU (if any) is stored.
        cand_valid = 1'b1;
        cand_idx   = I_MemRegIdx;
        cand_data  = I_MemData;
        p0_idx     = I_AluRegIdx;
        p0_data    = I_AluData;
        want       = {2'b00, I_AluValid};
      end else if (I_AluValid) begin
        cand_valid = 1'b1;
        cand_idx   = I_AluRegIdx;
        cand_data  = I_AluData;
      end
    end
    free   = wbq_free_slots(fifo_count, pop);
    drop   = want > free;
    push_n = drop ? free[1:0] : want[1:0];
  end

  wb_entry_fifo u_fifo (
    .clk        (I_CLOCK),
    .rst_n      (I_RESET_N),
    .pop        (pop),
    .push_n     (push_n),
    .push0_idx  (p0_idx),
    .push0_data (p0_data),
    .push1_idx  (p1_idx),
    .push1_data (p1_data),
    .head_idx   (head_idx),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_WriteBackEnable <= 1'b0;
      O_WriteBackRegIdx <= '0;
      O_WriteBackData   <= '0;
      O_Overflow        <= 1'b0;
    end else begin
      O_WriteBackEnable <= cand_valid;
      if (cand_valid) begin
        O_WriteBackRegIdx <= cand_idx;
        O_WriteBackData   <= cand_data;
      end
      if (drop) O_Overflow <= 1'b1;
    end
  end

  assign O_Count      = fifo_count;
  assign O_QueueStall = fifo_count >= 3'd3;
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 I_CLOCK  input  1  pipeline clock; all state updates on posedge.
REQ-003 I_RESET_N  input  1  asynchronous active-low reset.
REQ-004 I_LOCK  input  1  pipeline enable; 0 = freeze.
REQ-005 I_MemValid  input  1  load result from memory stage present.
REQ-006 I_MemRegIdx  input  4  load destination register.
REQ-007 I_MemData  input  REG_WIDTH  load result.
REQ-008 I_AluValid  input  1  ALU/MOV result from execute stage present.
REQ-009 I_AluRegIdx  input  4  ALU destination register.
REQ-010 I_AluData  input  REG_WIDTH  ALU result.
REQ-011 O_WriteBackEnable  output  1  one-cycle write strobe to decode.
REQ-012 O_WriteBackRegIdx  output  4  register index to decode.
REQ-013 O_WriteBackData  output  REG_WIDTH  write data to decode.
REQ-014 O_QueueStall  output  1  backpressure to fetch/decode.
REQ-015 O_Count  output  3  stored entries, 0..4.
REQ-016 O_Overflow  output  1  sticky error: a result was dropped.

Function
REQ-017 The block SHALL hold WBQ_DEPTH=4 entries {RegIdx, Data} in strict FIFO order.
REQ-018 On each posedge with I_LOCK=1, the candidate order SHALL be: stored entries (oldest first), then Mem input, then ALU input; Mem is program-older than ALU.
REQ-019 The first candidate SHALL load the output register with O_WriteBackEnable<=1; with no candidate, O_WriteBackEnable<=0 and index/data hold.
REQ-020 The remaining candidates SHALL be stored; an empty queue with one push SHALL reach the output after one posedge (bypass, latency 1).
REQ-021 At most one writeback SHALL issue per cycle; up to two pushes SHALL be accepted per cycle.
REQ-022 Capacity after pop SHALL be 4 - count + (count>0); candidates beyond capacity SHALL be dropped youngest-first and set O_Overflow.
REQ-023 O_QueueStall SHALL be combinational: 1 when O_Count>=3.
REQ-024 With I_LOCK=0, inputs SHALL be ignored, entries and O_Count held, O_WriteBackEnable<=0.
REQ-025 Repeated writes to the same RegIdx SHALL be issued in order, with no merging.
REQ-026 O_Count SHALL be registered and equal the stored entries, excluding the output register.

Reset
REQ-027 On I_RESET_N=0, immediately: O_WriteBackEnable=0, O_WriteBackRegIdx=0, O_WriteBackData=0, O_Count=0, O_Overflow=0, all entries invalid.
REQ-028 Reset mid-operation SHALL discard all pending entries with no further strobes; O_Overflow clears only on reset.

Structure
REQ-029 REG_WIDTH comes from global_def.h; WBQ_DEPTH=4 and the entry field widths SHALL be added there.
REQ-030 Storage SHALL be one sub-module wb_entry_fifo: circular buffer with 2-bit pointers and a 3-bit count, supporting 1 pop and 0..2 pushes per cycle.
REQ-031 Implementation SHALL be 120-400 lines of RTL with no latches.

Verification
REQ-032 Empty queue; Mem {R3, 16'h0005} -> next cycle strobe R3=5, O_Count=0.
REQ-033 Same cycle Mem {R1, 16'h0011}, ALU {R2, 16'h0022} -> R1 strobe, then R2 strobe the next cycle, O_Count 1 then 0.
REQ-034 Dual pushes for 3 cycles -> O_QueueStall=1 once O_Count=3; a push at count 4 -> O_Overflow=1, youngest entry absent from output.
REQ-035 I_LOCK=0 for 2 cycles with 2 entries stored -> no strobe, O_Count stays 2; I_LOCK=1 -> strobes resume in order.
REQ-036 Async reset asserted between edges with 3 entries stored -> outputs zero immediately; no strobe after release.
REQ-037 ALU {R4, 16'h8000} then ALU {R4, 16'h0000} -> two strobes to R4 in order (N data, then zero data).
